// File: rtl/cordic_range_reducer.sv
// Range reducer wrapped around the 16-iteration cordic core: bit-serial mod-360 reduction,
// fold into [-90, 90] degrees, core handshake and quadrant sign fix on cosine.
`timescale 1ns/1ps
module cordic_range_reducer #(
  parameter int ANGLE_W = 48
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [ANGLE_W-1:0] i_in_angle,
  output logic               o_cor_s,
  output logic [31:0]        o_cor_angle,
  input  logic               i_cor_done,
  input  logic [31:0]        i_cor_sine,
  input  logic [31:0]        i_cor_cosine,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [31:0]        o_out_sine,
  output logic [31:0]        o_out_cosine,
  output logic               o_busy
);

  localparam int CNT_W = $clog2(ANGLE_W);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REDUCE = 3'd1;
  localparam logic [2:0] S_FOLD   = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_OUT    = 3'd4;

  localparam logic        [32:0] DIV   = 33'd3600000000;
  localparam logic signed [33:0] FULL  = 34'sd3600000000;
  localparam logic signed [33:0] HALF  = 34'sd1800000000;
  localparam logic signed [33:0] QUART = 34'sd900000000;

  logic [2:0]         r_state;
  logic               r_sign;
  logic [ANGLE_W-1:0] r_mag;
  logic [31:0]        r_rem;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg;
  logic               r_in_ready;
  logic               r_busy;
  logic               r_cor_s;
  logic [31:0]        r_cor_angle;
  logic               r_out_valid;
  logic [31:0]        r_out_sine;
  logic [31:0]        r_out_cosine;

  logic [32:0]        w_shift;
  logic [31:0]        w_rem_next;
  logic signed [33:0] w_r0;
  logic signed [33:0] w_r1;
  logic signed [31:0] w_a;
  logic               w_neg;

  // Restoring remainder step: the magnitude is consumed MSB-first by shifting it left.
  always_comb begin
    w_shift    = {r_rem, r_mag[ANGLE_W-1]};
    w_rem_next = w_shift[31:0];
    if (w_shift >= DIV) begin
      w_rem_next = 32'(w_shift - DIV);
    end else begin
      w_rem_next = w_shift[31:0];
    end
  end

  // Fold the signed remainder into (-180, 180], then into [-90, 90] remembering the cosine flip.
  always_comb begin
    w_r0  = r_sign ? -$signed({2'b00, r_rem}) : $signed({2'b00, r_rem});
    w_r1  = w_r0;
    w_a   = 32'sd0;
    w_neg = 1'b0;
    if (w_r0 > HALF) begin
      w_r1 = w_r0 - FULL;
    end else if (w_r0 <= -HALF) begin
      w_r1 = w_r0 + FULL;
    end else begin
      w_r1 = w_r0;
    end
    if (w_r1 > QUART) begin
      w_a   = 32'(HALF - w_r1);
      w_neg = 1'b1;
    end else if (w_r1 < -QUART) begin
      w_a   = 32'(-HALF - w_r1);
      w_neg = 1'b1;
    end else begin
      w_a   = 32'(w_r1);
      w_neg = 1'b0;
    end
  end

  // Control sequence and every registered output.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_sign       <= 1'b0;
      r_mag        <= '0;
      r_rem        <= 32'd0;
      r_cnt        <= '0;
      r_neg        <= 1'b0;
      r_in_ready   <= 1'b1;
      r_busy       <= 1'b0;
      r_cor_s      <= 1'b0;
      r_cor_angle  <= 32'd0;
      r_out_valid  <= 1'b0;
      r_out_sine   <= 32'd0;
      r_out_cosine <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_sign     <= i_in_angle[ANGLE_W-1];
            r_mag      <= i_in_angle[ANGLE_W-1] ? -i_in_angle : i_in_angle;
            r_rem      <= 32'd0;
            r_cnt      <= CNT_W'(ANGLE_W - 1);
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_REDUCE;
          end
        end
        S_REDUCE: begin
          r_rem <= w_rem_next;
          r_mag <= r_mag << 1;
          if (r_cnt == '0) begin
            r_state <= S_FOLD;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_FOLD: begin
          r_cor_angle <= w_a;
          r_neg       <= w_neg;
          r_cor_s     <= 1'b1;
          r_state     <= S_RUN;
        end
        S_RUN: begin
          if (i_cor_done) begin
            r_out_sine   <= i_cor_sine;
            r_out_cosine <= r_neg ? -i_cor_cosine : i_cor_cosine;
            r_cor_s      <= 1'b0;
            r_out_valid  <= 1'b1;
            r_state      <= S_OUT;
          end
        end
        S_OUT: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_cor_s     <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_busy       = r_busy;
  assign o_cor_s      = r_cor_s;
  assign o_cor_angle  = r_cor_angle;
  assign o_out_valid  = r_out_valid;
  assign o_out_sine   = r_out_sine;
  assign o_out_cosine = r_out_cosine;

endmodule
